fetch_unit: RTL and testbench

//  Instruction-fetch stage and IF/ID register for the pipelined MIPS datapath. Owns the PC,

---
 rtl/fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_fetch_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage plus the IF/ID register.
// Owns the fetch PC, issues reads to a synchronous program memory, and hands
// instructions to decode over a valid/ready handshake. A one-entry skid buffer
// catches the read that is already in flight when decode stalls, so no
// instruction is lost or repeated. Redirects from decode flush everything
// buffered or in flight and restart fetch at the target.
module fetch_unit #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    BIT_WIDTH       = 32,
  parameter int                    IMEM_ADDR_WIDTH = 6,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_valid,
  input  logic [ADDR_WIDTH-1:0]      redirect_pc,
  output logic                       imem_en,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic [BIT_WIDTH-1:0]       imem_q,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [BIT_WIDTH-1:0]       id_instr,
  output logic [ADDR_WIDTH-1:0]      id_pc,
  output logic [ADDR_WIDTH-1:0]      id_pc_plus4
);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] WORD_MSK = ~ADDR_WIDTH'(3);

  // fetch PC
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  // read issued last cycle; its data is on imem_q this cycle
  logic                  if_v_q, if_v_d;
  logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;

  // output register presented to decode
  logic                  o_v_q, o_v_d;
  logic [BIT_WIDTH-1:0]  o_instr_q, o_instr_d;
  logic [ADDR_WIDTH-1:0] o_pc_q, o_pc_d;
  logic [ADDR_WIDTH-1:0] o_pc4_q, o_pc4_d;

  // skid register behind the output register
  logic                  s_v_q, s_v_d;
  logic [BIT_WIDTH-1:0]  s_instr_q, s_instr_d;
  logic [ADDR_WIDTH-1:0] s_pc_q, s_pc_d;

  logic       xfer;
  logic       o_free;
  logic [1:0] occ;
  logic       issue;

  // Occupancy counts every slot that will still hold an instruction after this
  // cycle's handshake. Issuing only at occ <= 1 leaves room for the new read
  // even if decode then stalls, which is why S is always empty when a return
  // lands on a held O.
  always_comb begin
    xfer   = o_v_q & id_ready;
    o_free = ~o_v_q | xfer;
    occ    = {1'b0, o_v_q} + {1'b0, s_v_q} + {1'b0, if_v_q} - {1'b0, xfer};
    issue  = (occ <= 2'd1) & ~redirect_valid;
  end

  // memory interface; held low while reset is asserted
  always_comb begin
    imem_en   = issue & rst;
    imem_addr = pc_q[IMEM_ADDR_WIDTH+1:2];
  end

  // decode-facing outputs come straight from the output register
  always_comb begin
    id_valid    = o_v_q;
    id_instr    = o_instr_q;
    id_pc       = o_pc_q;
    id_pc_plus4 = o_pc4_q;
  end

  // next-state: redirect flush, issue, and the return/skid path
  always_comb begin
    pc_d      = pc_q;
    if_v_d    = if_v_q;
    if_pc_d   = if_pc_q;
    o_v_d     = o_v_q;
    o_instr_d = o_instr_q;
    o_pc_d    = o_pc_q;
    o_pc4_d   = o_pc4_q;
    s_v_d     = s_v_q;
    s_instr_d = s_instr_q;
    s_pc_d    = s_pc_q;

    if (redirect_valid) begin
      // Any transfer this cycle has already happened on the handshake; the
      // remaining buffered and in-flight instructions are wrong-path.
      pc_d   = redirect_pc & WORD_MSK;
      if_v_d = 1'b0;
      o_v_d  = 1'b0;
      s_v_d  = 1'b0;
    end else begin
      if (issue) begin
        if_v_d  = 1'b1;
        if_pc_d = pc_q;
        pc_d    = pc_q + PC_STEP;
      end else begin
        if_v_d = 1'b0;
      end

      if (o_free) begin
        if (s_v_q) begin
          // skid entry is older than any returning read, so it goes first
          o_v_d     = 1'b1;
          o_instr_d = s_instr_q;
          o_pc_d    = s_pc_q;
          o_pc4_d   = s_pc_q + PC_STEP;
          if (if_v_q) begin
            s_instr_d = imem_q;
            s_pc_d    = if_pc_q;
          end else begin
            s_v_d = 1'b0;
          end
        end else if (if_v_q) begin
          o_v_d     = 1'b1;
          o_instr_d = imem_q;
          o_pc_d    = if_pc_q;
          o_pc4_d   = if_pc_q + PC_STEP;
        end else begin
          o_v_d = 1'b0;
        end
      end else if (if_v_q) begin
        s_v_d     = 1'b1;
        s_instr_d = imem_q;
        s_pc_d    = if_pc_q;
      end
    end
  end

  // state registers; reset drops everything and restarts at RESET_PC
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      if_v_q    <= 1'b0;
      if_pc_q   <= '0;
      o_v_q     <= 1'b0;
      o_instr_q <= '0;
      o_pc_q    <= '0;
      o_pc4_q   <= '0;
      s_v_q     <= 1'b0;
      s_instr_q <= '0;
      s_pc_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      if_v_q    <= if_v_d;
      if_pc_q   <= if_pc_d;
      o_v_q     <= o_v_d;
      o_instr_q <= o_instr_d;
      o_pc_q    <= o_pc_d;
      o_pc4_q   <= o_pc4_d;
      s_v_q     <= s_v_d;
      s_instr_q <= s_instr_d;
      s_pc_q    <= s_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirects, PC wrap, reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [5:0]  imem_addr;
  logic [31:0] imem_q;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  logic [31:0] mem [0:63];
  int n_cmp = 0;
  int n_err = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_q(imem_q),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_en) imem_q <= mem[imem_addr];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    step(); step();
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", id_valid); end
    n_cmp++; if (id_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc got %h exp 0", id_pc); end
    n_cmp++; if (id_pc_plus4 !== 32'h0) begin n_err++; $display("FAIL rst_pc4 got %h exp 0", id_pc_plus4); end
    n_cmp++; if (id_instr !== 32'h0) begin n_err++; $display("FAIL rst_instr got %h exp 0", id_instr); end
    n_cmp++; if (imem_en !== 1'b0) begin n_err++; $display("FAIL rst_imem_en got %b exp 0", imem_en); end
  endtask

  // after release: issue in cycle 0, first valid in cycle 2, then one per cycle
  task automatic test_stream();
    rst = 1'b1; #1;
    n_cmp++; if (imem_en !== 1'b1 || imem_addr !== 6'd0) begin n_err++; $display("FAIL strm_issue got en=%b addr=%0d exp en=1 addr=0", imem_en, imem_addr); end
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL strm_c0 got %b exp 0", id_valid); end
    step();
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL strm_c1 got %b exp 0", id_valid); end
    step();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h1000_0000 || id_pc_plus4 !== 32'h4) begin n_err++; $display("FAIL strm_c2 got v=%b pc=%h i=%h p4=%h exp v=1 pc=0 i=10000000 p4=4", id_valid, id_pc, id_instr, id_pc_plus4); end
    step();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h4 || id_instr !== 32'h1000_0001) begin n_err++; $display("FAIL strm_c3 got v=%b pc=%h i=%h exp v=1 pc=4 i=10000001", id_valid, id_pc, id_instr); end
    step();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h8 || id_instr !== 32'h1000_0002) begin n_err++; $display("FAIL strm_c4 got v=%b pc=%h i=%h exp v=1 pc=8 i=10000002", id_valid, id_pc, id_instr); end
  endtask

  // O holds @0x8, skid catches @0xC, no issue while stalled
  task automatic test_stall();
    logic [31:0] exp_pc [0:2];
    exp_pc[0] = 32'h0C; exp_pc[1] = 32'h10; exp_pc[2] = 32'h14;
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h8 || id_instr !== 32'h1000_0002 || imem_en !== 1'b0) begin n_err++; $display("FAIL stall_hold%0d got v=%b pc=%h i=%h en=%b exp v=1 pc=8 i=10000002 en=0", i, id_valid, id_pc, id_instr, imem_en); end
      step();
    end
    id_ready = 1'b1; #1;
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h8 || imem_en !== 1'b1) begin n_err++; $display("FAIL stall_release got v=%b pc=%h en=%b exp v=1 pc=8 en=1", id_valid, id_pc, imem_en); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (id_valid !== 1'b1 || id_pc !== exp_pc[i] || id_instr !== (32'h1000_0000 + (exp_pc[i] >> 2))) begin n_err++; $display("FAIL stall_drain%0d got v=%b pc=%h i=%h exp v=1 pc=%h", i, id_valid, id_pc, id_instr, exp_pc[i]); end
    end
  endtask

  // redirect while @0x14 transfers: wrong-path @0x18/@0x1C never appear
  task automatic test_redirect_stream();
    redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
    n_cmp++; if (imem_en !== 1'b0) begin n_err++; $display("FAIL redir_en got %b exp 0", imem_en); end
    step();
    redirect_valid = 1'b0; #1;
    n_cmp++; if (id_valid !== 1'b0 || imem_addr !== 6'd16 || imem_en !== 1'b1) begin n_err++; $display("FAIL redir_r1 got v=%b addr=%0d en=%b exp v=0 addr=16 en=1", id_valid, imem_addr, imem_en); end
    step();
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL redir_r2 got %b exp 0", id_valid); end
    step();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_instr !== 32'h1000_0010) begin n_err++; $display("FAIL redir_r3 got v=%b pc=%h i=%h exp v=1 pc=40 i=10000010", id_valid, id_pc, id_instr); end
    step();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h44 || id_pc_plus4 !== 32'h48) begin n_err++; $display("FAIL redir_r4 got v=%b pc=%h p4=%h exp v=1 pc=44 p4=48", id_valid, id_pc, id_pc_plus4); end
  endtask

  // stall until O=@0x44 and S=@0x48, then redirect to 0x23 -> fetch from 0x20
  task automatic test_redirect_stall();
    id_ready = 1'b0;
    step(); step();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h44 || imem_en !== 1'b0) begin n_err++; $display("FAIL rstall_full got v=%b pc=%h en=%b exp v=1 pc=44 en=0", id_valid, id_pc, imem_en); end
    redirect_valid = 1'b1; redirect_pc = 32'h23;
    step();
    redirect_valid = 1'b0; id_ready = 1'b1; #1;
    n_cmp++; if (id_valid !== 1'b0 || imem_addr !== 6'd8 || imem_en !== 1'b1) begin n_err++; $display("FAIL rstall_r1 got v=%b addr=%0d en=%b exp v=0 addr=8 en=1", id_valid, imem_addr, imem_en); end
    step();
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rstall_r2 got %b exp 0", id_valid); end
    step();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h20 || id_instr !== 32'h1000_0008) begin n_err++; $display("FAIL rstall_r3 got v=%b pc=%h i=%h exp v=1 pc=20 i=10000008", id_valid, id_pc, id_instr); end
    step();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h24) begin n_err++; $display("FAIL rstall_r4 got v=%b pc=%h exp v=1 pc=24", id_valid, id_pc); end
  endtask

  // redirect to the top word: PC and pc_plus4 wrap, imem_addr aliases
  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0; #1;
    n_cmp++; if (imem_addr !== 6'd63 || imem_en !== 1'b1) begin n_err++; $display("FAIL wrap_addr63 got addr=%0d en=%b exp addr=63 en=1", imem_addr, imem_en); end
    step();
    n_cmp++; if (imem_addr !== 6'd0 || id_valid !== 1'b0) begin n_err++; $display("FAIL wrap_addr0 got addr=%0d v=%b exp addr=0 v=0", imem_addr, id_valid); end
    step();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0 || id_instr !== 32'h1000_003F) begin n_err++; $display("FAIL wrap_top got v=%b pc=%h p4=%h i=%h exp v=1 pc=fffffffc p4=0 i=1000003f", id_valid, id_pc, id_pc_plus4, id_instr); end
    step();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_pc_plus4 !== 32'h4 || id_instr !== 32'h1000_0000) begin n_err++; $display("FAIL wrap_zero got v=%b pc=%h p4=%h i=%h exp v=1 pc=0 p4=4 i=10000000", id_valid, id_pc, id_pc_plus4, id_instr); end
  endtask

  // reset asserted with O=@0x0 and S=@0x4 full
  task automatic test_reset_mid();
    id_ready = 1'b0;
    step(); step();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin n_err++; $display("FAIL rmid_pre got v=%b pc=%h exp v=1 pc=0", id_valid, id_pc); end
    rst = 1'b0; #1;
    n_cmp++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== 32'h0 || id_pc_plus4 !== 32'h0 || imem_en !== 1'b0) begin n_err++; $display("FAIL rmid_clear got v=%b pc=%h i=%h p4=%h en=%b exp all 0", id_valid, id_pc, id_instr, id_pc_plus4, imem_en); end
    step();
    rst = 1'b1; id_ready = 1'b1; #1;
    n_cmp++; if (imem_en !== 1'b1 || imem_addr !== 6'd0) begin n_err++; $display("FAIL rmid_issue got en=%b addr=%0d exp en=1 addr=0", imem_en, imem_addr); end
    step();
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rmid_c1 got %b exp 0", id_valid); end
    step();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h1000_0000) begin n_err++; $display("FAIL rmid_c2 got v=%b pc=%h i=%h exp v=1 pc=0 i=10000000", id_valid, id_pc, id_instr); end
    step();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h4 || id_instr !== 32'h1000_0001) begin n_err++; $display("FAIL rmid_c3 got v=%b pc=%h i=%h exp v=1 pc=4 i=10000001", id_valid, id_pc, id_instr); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    imem_q = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_stream();
    test_redirect_stall();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
